// File: rtl/clock_controller.sv
// rtl/clock_controller.sv - programmable CPU clock generator with run, step, burst and halt control
module clock_controller #(
    parameter int                   DIV_WIDTH   = 24,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = {DIV_WIDTH{1'b1}},
    parameter int                   BURST_WIDTH = 16,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                   i_SYS_CLOCK,
    input  logic                   i_RESET,
    input  logic                   i_HALT,
    input  logic [1:0]             i_MODE,
    input  logic                   i_STEP,
    input  logic                   i_BURST_START,
    input  logic [BURST_WIDTH-1:0] i_BURST_COUNT,
    input  logic                   i_DIV_LOAD,
    input  logic [DIV_WIDTH-1:0]   i_DIV_VALUE,
    output logic                   o_CLOCK,
    output logic                   o_CLOCK_n,
    output logic                   o_CLOCK_RISE,
    output logic                   o_CLOCK_FALL,
    output logic [1:0]             o_STATE,
    output logic                   o_BURST_DONE
);

    // A single flop cannot filter metastability, so the chain never drops below two stages.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0]             MODE_RUN   = 2'b00;
    localparam logic [1:0]             MODE_STEP  = 2'b01;
    localparam logic [1:0]             MODE_BURST = 2'b10;
    localparam logic [BURST_WIDTH-1:0] ONE_PULSE  = 1;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_PULSE   = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_active_q, div_active_d;
    logic [DIV_WIDTH-1:0]   div_shadow_q;
    logic [BURST_WIDTH-1:0] pulses_left_q, pulses_left_d;
    logic                   clk_q, clk_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   done_q, done_d;
    logic                   halt_pending_q, halt_pending_d;
    logic                   stop_pending_q, stop_pending_d;

    logic [SYNC_N-1:0]      step_sync_q;
    logic                   step_prev_q;
    logic                   step_edge_q;

    logic                   phase_end;
    logic                   halt_req;
    logic                   run_stop_req;
    logic [DIV_WIDTH-1:0]   div_next;

    assign phase_end    = (cnt_q == div_active_q);
    assign halt_req     = i_HALT | halt_pending_q;
    assign run_stop_req = (i_MODE != MODE_RUN) | stop_pending_q;
    // A load landing on the toggle cycle is applied to the very next phase.
    assign div_next     = i_DIV_LOAD ? i_DIV_VALUE : div_shadow_q;

    assign o_CLOCK      = clk_q;
    assign o_CLOCK_n    = ~clk_q;
    assign o_CLOCK_RISE = rise_q;
    assign o_CLOCK_FALL = fall_q;
    assign o_STATE      = state_q;
    assign o_BURST_DONE = done_q;

    // Next-state, phase engine and strobe generation; halt always outranks every other request.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        div_active_d   = div_active_q;
        pulses_left_d  = pulses_left_q;
        clk_d          = clk_q;
        rise_d         = 1'b0;
        fall_d         = 1'b0;
        done_d         = 1'b0;
        halt_pending_d = halt_pending_q;
        stop_pending_d = stop_pending_q;

        unique case (state_q)
            ST_STOPPED: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (i_DIV_LOAD) begin
                    div_active_d = i_DIV_VALUE;
                end
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else begin
                    case (i_MODE)
                        MODE_RUN: begin
                            state_d = ST_RUN;
                        end
                        MODE_STEP: begin
                            if (step_edge_q) begin
                                state_d       = ST_PULSE;
                                pulses_left_d = ONE_PULSE;
                            end
                        end
                        MODE_BURST: begin
                            if (i_BURST_START && (i_BURST_COUNT != '0)) begin
                                state_d       = ST_PULSE;
                                pulses_left_d = i_BURST_COUNT;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_RUN, ST_PULSE: begin
                // A stop or halt seen during the high phase is remembered until the falling toggle.
                if (halt_req && clk_q) begin
                    halt_pending_d = 1'b1;
                end
                if ((state_q == ST_RUN) && clk_q && (i_MODE != MODE_RUN)) begin
                    stop_pending_d = 1'b1;
                end

                if (halt_req && !clk_q) begin
                    state_d       = ST_HALTED;
                    cnt_d         = '0;
                    pulses_left_d = '0;
                end else if ((state_q == ST_RUN) && !clk_q && run_stop_req) begin
                    state_d        = ST_STOPPED;
                    cnt_d          = '0;
                    stop_pending_d = 1'b0;
                end else if (phase_end) begin
                    clk_d        = ~clk_q;
                    cnt_d        = '0;
                    div_active_d = div_next;
                    rise_d       = ~clk_q;
                    fall_d       = clk_q;
                    if (clk_q) begin
                        if (halt_req) begin
                            state_d       = ST_HALTED;
                            pulses_left_d = '0;
                        end else if (state_q == ST_RUN) begin
                            if (run_stop_req) begin
                                state_d        = ST_STOPPED;
                                stop_pending_d = 1'b0;
                            end
                        end else begin
                            pulses_left_d = pulses_left_q - ONE_PULSE;
                            if (pulses_left_q == ONE_PULSE) begin
                                state_d = ST_STOPPED;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HALTED: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (i_DIV_LOAD) begin
                    div_active_d = i_DIV_VALUE;
                end
            end
        endcase
    end

    // State register together with the generated clock and its registered strobes.
    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_RESET) begin
            state_q        <= ST_STOPPED;
            cnt_q          <= '0;
            div_active_q   <= DEFAULT_DIV;
            pulses_left_q  <= '0;
            clk_q          <= 1'b0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
            done_q         <= 1'b0;
            halt_pending_q <= 1'b0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_active_q   <= div_active_d;
            pulses_left_q  <= pulses_left_d;
            clk_q          <= clk_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
            done_q         <= done_d;
            halt_pending_q <= halt_pending_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    // Shadow divisor captures every load; the phase engine picks it up at the next toggle.
    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_RESET) begin
            div_shadow_q <= DEFAULT_DIV;
        end else if (i_DIV_LOAD) begin
            div_shadow_q <= i_DIV_VALUE;
        end
    end

    // Step button synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_RESET) begin
            step_sync_q <= '0;
            step_prev_q <= 1'b0;
            step_edge_q <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[SYNC_N-2:0], i_STEP};
            step_prev_q <= step_sync_q[SYNC_N-1];
            step_edge_q <= step_sync_q[SYNC_N-1] & ~step_prev_q;
        end
    end

endmodule

// File: tb/tb_clock_controller.sv
// tb/tb_clock_controller.sv - directed self-checking bench for clock_controller
module tb_clock_controller;

    localparam int DW = 24;
    localparam int BW = 16;

    logic          i_SYS_CLOCK = 1'b0;
    logic          i_RESET;
    logic          i_HALT;
    logic [1:0]    i_MODE;
    logic          i_STEP;
    logic          i_BURST_START;
    logic [BW-1:0] i_BURST_COUNT;
    logic          i_DIV_LOAD;
    logic [DW-1:0] i_DIV_VALUE;
    logic          o_CLOCK;
    logic          o_CLOCK_n;
    logic          o_CLOCK_RISE;
    logic          o_CLOCK_FALL;
    logic [1:0]    o_STATE;
    logic          o_BURST_DONE;

    int checks = 0;
    int errors = 0;
    int bad_inv = 0;

    always #5 i_SYS_CLOCK = ~i_SYS_CLOCK;

    clock_controller #(
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(24'd3),
        .BURST_WIDTH(BW),
        .SYNC_STAGES(2)
    ) dut (
        .i_SYS_CLOCK  (i_SYS_CLOCK),
        .i_RESET      (i_RESET),
        .i_HALT       (i_HALT),
        .i_MODE       (i_MODE),
        .i_STEP       (i_STEP),
        .i_BURST_START(i_BURST_START),
        .i_BURST_COUNT(i_BURST_COUNT),
        .i_DIV_LOAD   (i_DIV_LOAD),
        .i_DIV_VALUE  (i_DIV_VALUE),
        .o_CLOCK      (o_CLOCK),
        .o_CLOCK_n    (o_CLOCK_n),
        .o_CLOCK_RISE (o_CLOCK_RISE),
        .o_CLOCK_FALL (o_CLOCK_FALL),
        .o_STATE      (o_STATE),
        .o_BURST_DONE (o_BURST_DONE)
    );

    always @(negedge i_SYS_CLOCK) begin
        if (!i_RESET && ((o_CLOCK_n !== ~o_CLOCK) || (o_CLOCK_RISE && o_CLOCK_FALL))) begin
            bad_inv++;
        end
    end

    task automatic tick();
        @(posedge i_SYS_CLOCK);
        #1;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_CLOCK_RISE && n < 64);
        if (!o_CLOCK_RISE) n = -1;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_CLOCK_FALL && n < 64);
        if (!o_CLOCK_FALL) n = -1;
    endtask

    task automatic wait_state(input logic [1:0] s, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (o_STATE !== s && n < 64);
        if (o_STATE !== s) n = -1;
    endtask

    task automatic load_div(input logic [DW-1:0] v);
        i_DIV_LOAD  = 1'b1;
        i_DIV_VALUE = v;
        tick();
        i_DIV_LOAD  = 1'b0;
    endtask

    task automatic pulse_reset();
        i_MODE  = 2'b11;
        i_HALT  = 1'b0;
        i_RESET = 1'b1;
        tick();
        i_RESET = 1'b0;
    endtask

    task automatic test_reset();
        i_RESET = 1'b1; i_HALT = 1'b0; i_MODE = 2'b11; i_STEP = 1'b0;
        i_BURST_START = 1'b0; i_BURST_COUNT = '0; i_DIV_LOAD = 1'b0; i_DIV_VALUE = '0;
        repeat (3) tick();
        checks++;
        if ({o_CLOCK, o_CLOCK_n, o_CLOCK_RISE, o_CLOCK_FALL, o_BURST_DONE} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 01000",
                     {o_CLOCK, o_CLOCK_n, o_CLOCK_RISE, o_CLOCK_FALL, o_BURST_DONE});
        end
        checks++;
        if (o_STATE !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d expected 0", o_STATE);
        end
        i_RESET = 1'b0;
        tick();
    endtask

    task automatic test_free_run();
        int n;
        i_MODE = 2'b00;
        tick();
        checks++;
        if (o_STATE !== 2'd1) begin
            errors++;
            $display("FAIL run_entry_state got %0d expected 1", o_STATE);
        end
        wait_rise(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL first_rise_latency got %0d expected 4", n); end
        wait_fall(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL high_phase got %0d expected 4", n); end
        wait_rise(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL low_phase got %0d expected 4", n); end
        checks++;
        if (o_CLOCK !== 1'b1) begin errors++; $display("FAIL clock_after_rise got %b expected 1", o_CLOCK); end
    endtask

    task automatic test_div_load();
        int n;
        i_DIV_LOAD  = 1'b1;
        i_DIV_VALUE = 24'd1;
        tick();
        i_DIV_LOAD  = 1'b0;
        wait_fall(n);
        checks++;
        if (n + 1 !== 4) begin errors++; $display("FAIL div_load_current_phase got %0d expected 4", n + 1); end
        wait_rise(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL div_load_low_phase got %0d expected 2", n); end
        wait_fall(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL div_load_high_phase got %0d expected 2", n); end
    endtask

    task automatic test_mode_stop();
        int rises;
        i_MODE = 2'b11;
        tick();
        checks++;
        if (o_STATE !== 2'd0 || o_CLOCK !== 1'b0) begin
            errors++;
            $display("FAIL stop_from_low got state %0d clock %b expected state 0 clock 0", o_STATE, o_CLOCK);
        end
        rises = 0;
        i_STEP = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) i_STEP = 1'b0;
            tick();
            if (o_CLOCK_RISE) rises++;
        end
        checks++;
        if (rises !== 0 || o_STATE !== 2'd0) begin
            errors++;
            $display("FAIL step_in_stop_mode got rises %0d state %0d expected 0 and 0", rises, o_STATE);
        end
    endtask

    task automatic test_single_step();
        int n;
        int rises;
        load_div(24'd2);
        i_MODE = 2'b01;
        i_STEP = 1'b1;
        wait_state(2'd2, n);
        i_STEP = 1'b0;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL step_to_pulse_latency got %0d expected 4", n); end
        wait_rise(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL step_rise_latency got %0d expected 3", n); end
        wait_fall(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL step_high_width got %0d expected 3", n); end
        checks++;
        if (o_BURST_DONE !== 1'b1 || o_STATE !== 2'd0) begin
            errors++;
            $display("FAIL step_done_at_fall got done %b state %0d expected 1 and 0", o_BURST_DONE, o_STATE);
        end
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_CLOCK_RISE || o_BURST_DONE) rises++;
        end
        checks++;
        if (rises !== 0) begin errors++; $display("FAIL step_single_pulse got extra %0d expected 0", rises); end
    endtask

    task automatic test_burst();
        int rises;
        int dones;
        i_MODE = 2'b10;
        load_div(24'd0);
        i_BURST_COUNT = 16'd5;
        i_BURST_START = 1'b1;
        tick();
        i_BURST_START = 1'b0;
        checks++;
        if (o_STATE !== 2'd2) begin errors++; $display("FAIL burst_entry_state got %0d expected 2", o_STATE); end
        rises = 0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_CLOCK_RISE) rises++;
            if (o_BURST_DONE) dones++;
        end
        checks++;
        if (rises !== 5) begin errors++; $display("FAIL burst_rises got %0d expected 5", rises); end
        checks++;
        if (dones !== 1 || o_STATE !== 2'd0) begin
            errors++;
            $display("FAIL burst_done got dones %0d state %0d expected 1 and 0", dones, o_STATE);
        end
        i_BURST_COUNT = 16'd0;
        i_BURST_START = 1'b1;
        tick();
        i_BURST_START = 1'b0;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_CLOCK_RISE || o_BURST_DONE || o_STATE !== 2'd0) rises++;
        end
        checks++;
        if (rises !== 0) begin errors++; $display("FAIL burst_zero_count got activity %0d expected 0", rises); end
    endtask

    task automatic test_halt_high();
        int n;
        int bad;
        load_div(24'd3);
        i_MODE = 2'b00;
        tick();
        wait_rise(n);
        i_HALT = 1'b1;
        tick();
        i_HALT = 1'b0;
        wait_fall(n);
        checks++;
        if (n + 1 !== 4) begin errors++; $display("FAIL halt_high_phase got %0d expected 4", n + 1); end
        checks++;
        if (o_STATE !== 2'd3 || o_CLOCK !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry got state %0d clock %b expected 3 and 0", o_STATE, o_CLOCK);
        end
        bad = 0;
        i_MODE = 2'b01;
        for (int i = 0; i < 24; i++) begin
            i_STEP = (i % 8) < 4;
            tick();
            if (o_CLOCK !== 1'b0 || o_CLOCK_RISE || o_STATE !== 2'd3) bad++;
        end
        i_STEP = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL halt_hold got violations %0d expected 0", bad); end
        pulse_reset();
        checks++;
        if (o_STATE !== 2'd0) begin errors++; $display("FAIL halt_reset_exit got %0d expected 0", o_STATE); end
    endtask

    task automatic test_halt_low();
        int n;
        i_MODE = 2'b00;
        tick();
        wait_rise(n);
        wait_fall(n);
        i_HALT = 1'b1;
        tick();
        i_HALT = 1'b0;
        checks++;
        if (o_STATE !== 2'd3 || o_CLOCK !== 1'b0) begin
            errors++;
            $display("FAIL halt_from_low got state %0d clock %b expected 3 and 0", o_STATE, o_CLOCK);
        end
        pulse_reset();
    endtask

    task automatic test_burst_abort();
        int n;
        int dones;
        i_MODE = 2'b10;
        i_BURST_COUNT = 16'd3;
        i_BURST_START = 1'b1;
        tick();
        i_BURST_START = 1'b0;
        wait_rise(n);
        i_HALT = 1'b1;
        tick();
        i_HALT = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_BURST_DONE) dones++;
        end
        checks++;
        if (dones !== 0 || o_STATE !== 2'd3) begin
            errors++;
            $display("FAIL burst_abort got dones %0d state %0d expected 0 and 3", dones, o_STATE);
        end
        pulse_reset();
    endtask

    task automatic test_invariants();
        checks++;
        if (bad_inv !== 0) begin
            errors++;
            $display("FAIL clock_n_and_strobe_exclusive got violations %0d expected 0", bad_inv);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_div_load();
        test_mode_stop();
        test_single_step();
        test_burst();
        test_halt_high();
        test_halt_low();
        test_burst_abort();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
